// File: rtl/key_pkg.sv
// ----------------------------------------------------------------------------
// key_pkg
//
// Shared constants and types for the key event path.
//   - KEY_DEBOUNCE_DEFAULT       default stable-cycle count before the
//                                debounced level may change
//   - KEY_REPEAT_DELAY_DEFAULT   default hold time before the first repeat
//   - KEY_REPEAT_RATE_DEFAULT    default spacing between later repeats
//   - KEY_ID_W                   id field width, wide enough for 16 keys
//   - key_evt_t                  one queued/presented event (id + repeat flag)
//   - keyCountWidth / keyMax     width helpers for counters
// ----------------------------------------------------------------------------
package key_pkg;

    localparam int KEY_DEBOUNCE_DEFAULT     = 16;
    localparam int KEY_REPEAT_DELAY_DEFAULT = 500000;
    localparam int KEY_REPEAT_RATE_DEFAULT  = 100000;

    // Largest supported bank is 16 keys, so 4 id bits always suffice.
    localparam int KEY_ID_W = 4;

    typedef struct packed {
        logic [KEY_ID_W-1:0] id;
        logic                isRepeat;
    } key_evt_t;

    // Bits needed for a counter that runs 0 .. maxCount-1 (at least 1 bit).
    function automatic int keyCountWidth(input int maxCount);
        return (maxCount < 2) ? 1 : $clog2(maxCount);
    endfunction

    function automatic int keyMax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
//
// One key: 2-FF synchronizer, debounce counter, debounced level flop and a
// registered one-cycle pulse on each debounced press.
//
// Ports:
//   clk      in   clock, all state on posedge
//   reset    in   asynchronous, active-high reset (key reads as released)
//   keyN     in   raw key, asynchronous, 0 = pressed
//   pressed  out  debounced level, 1 = held
//   rise     out  one-cycle pulse, registered together with pressed 0->1
// ----------------------------------------------------------------------------
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic keyN,
    output logic pressed,
    output logic rise
);

    localparam int CW = keyCountWidth(DEBOUNCE_CYCLES);

    // The counter counts the differing cycles already seen. The level flips on
    // the cycle that would make it DEBOUNCE_CYCLES-1, so a press settles
    // DEBOUNCE_CYCLES+1 edges after the raw input changes (2 sync edges plus
    // DEBOUNCE_CYCLES-1 differing edges).
    localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 2);

    logic          syncA;
    logic          syncB;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncA   <= 1'b0;
            syncB   <= 1'b0;
            cnt     <= '0;
            pressed <= 1'b0;
            rise    <= 1'b0;
        end else begin
            syncA <= ~keyN;
            syncB <= syncA;
            rise  <= 1'b0;
            if (syncB == pressed) begin
                cnt <= '0;
            end else if (cnt == LAST_CNT) begin
                cnt     <= '0;
                pressed <= ~pressed;
                rise    <= ~pressed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// ----------------------------------------------------------------------------
// key_event_arbiter
//
// Debounces a bank of active-low keys, keeps at most one pending press event
// per key and serializes those events round-robin onto one valid/ready stream.
//
// Optional feature macro: KEY_AUTOREPEAT_EN
//   defined   - held keys produce repeat events (event_repeat=1) after
//               REPEAT_DELAY cycles and then every REPEAT_RATE cycles
//   undefined - no hold counters; event_repeat is always 0
//
// Ports:
//   clk           in   clock, all state on posedge
//   reset         in   asynchronous, active-high reset
//   keysN         in   raw keys, 0 = pressed
//   pressed       out  debounced levels, 1 = held
//   event_valid   out  event_id / event_repeat are valid
//   event_ready   in   consumer accepts when event_valid && event_ready
//   event_id      out  index of the key that produced the event
//   event_repeat  out  1 = auto-repeat event, 0 = fresh press
//   overflow      out  one-cycle pulse when an edge is dropped
//
// Handshake: an event transfers on every rising clk edge where event_valid
// and event_ready are both 1. While event_valid=1 and event_ready=0 the
// event_id/event_repeat pair is frozen and event_valid stays high. The slot
// is refilled in the same cycle it is emptied, so with event_ready held high
// one event moves per cycle.
// ----------------------------------------------------------------------------
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE     = KEY_REPEAT_RATE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         keysN,
    output logic [NUM_KEYS-1:0]         pressed,
    output logic                        event_valid,
    input  logic                        event_ready,
    output logic [$clog2(NUM_KEYS)-1:0] event_id,
    output logic                        event_repeat,
    output logic                        overflow
);

    localparam int IDW = $clog2(NUM_KEYS);

    // Elaboration-time parameter legality.
    if (NUM_KEYS < 2 || NUM_KEYS > 16) begin : gBadNumKeys
        $error("key_event_arbiter: NUM_KEYS must be 2..16");
    end
    if (DEBOUNCE_CYCLES < 2) begin : gBadDebounce
        $error("key_event_arbiter: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : gBadRepeat
        $error("key_event_arbiter: REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    logic [NUM_KEYS-1:0] pressEdge;   // debounced press pulses
    logic [NUM_KEYS-1:0] repEdge;     // auto-repeat pulses
    logic [NUM_KEYS-1:0] setMask;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] pendRep;
    logic [NUM_KEYS-1:0] pendingNext;
    logic [NUM_KEYS-1:0] pendRepNext;
    logic [NUM_KEYS-1:0] grantMask;
    logic [NUM_KEYS-1:0] slotBusy;
    logic [NUM_KEYS-1:0] dropMask;
    logic [NUM_KEYS-1:0] acceptMask;

    key_evt_t            slot;
    key_evt_t            slotNext;
    logic                slotValidNext;
    logic                slotFree;
    logic                found;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      ptrNext;
    logic [IDW-1:0]      scanIdx;

    // ------------------------------------------------------------------
    // Per-key debounce
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_KEYS; i++) begin : gKey
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uDebounce (
            .clk    (clk),
            .reset  (reset),
            .keyN   (keysN[i]),
            .pressed(pressed[i]),
            .rise   (pressEdge[i])
        );
    end

    // ------------------------------------------------------------------
    // Auto-repeat hold counters
    // ------------------------------------------------------------------
`ifdef KEY_AUTOREPEAT_EN
    localparam int HOLD_W = keyCountWidth(keyMax(REPEAT_DELAY, REPEAT_RATE));

    for (genvar i = 0; i < NUM_KEYS; i++) begin : gHold
        logic [HOLD_W-1:0] holdCnt;
        logic              repeating;   // first repeat already issued
        logic              repPulse;

        // The counter runs from the cycle after pressed rises, so the first
        // repeat pulse lands exactly REPEAT_DELAY cycles after the press
        // pulse and later ones REPEAT_RATE cycles apart.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                holdCnt   <= '0;
                repeating <= 1'b0;
                repPulse  <= 1'b0;
            end else begin
                repPulse <= 1'b0;
                if (!pressed[i]) begin
                    holdCnt   <= '0;
                    repeating <= 1'b0;
                end else if ((!repeating && holdCnt == HOLD_W'(REPEAT_DELAY - 1)) ||
                             ( repeating && holdCnt == HOLD_W'(REPEAT_RATE - 1))) begin
                    holdCnt   <= '0;
                    repeating <= 1'b1;
                    repPulse  <= 1'b1;
                end else begin
                    holdCnt <= holdCnt + 1'b1;
                end
            end
        end

        assign repEdge[i] = repPulse;
    end
`else
    // No repeats: pendRep and slot.isRepeat stay 0, so event_repeat is
    // constant 0.
    assign repEdge = '0;
`endif

    assign setMask = pressEdge | repEdge;

    // ------------------------------------------------------------------
    // Arbitration, pending bookkeeping and output slot
    // ------------------------------------------------------------------
    always_comb begin
        slotFree      = !event_valid || event_ready;
        grantMask     = '0;
        found         = 1'b0;
        ptrNext       = ptr;
        scanIdx       = '0;
        slotValidNext = event_valid && !event_ready;
        slotNext      = slot;
        slotBusy      = '0;

        // Scan starts one past the last grant so every key gets a turn.
        for (int k = 1; k <= NUM_KEYS; k++) begin
            scanIdx = (int'(ptr) + k >= NUM_KEYS) ? IDW'(int'(ptr) + k - NUM_KEYS)
                                                   : IDW'(int'(ptr) + k);
            if (slotFree && !found && pending[scanIdx]) begin
                found              = 1'b1;
                grantMask[scanIdx] = 1'b1;
                ptrNext            = scanIdx;
            end
        end

        if (found) begin
            slotValidNext     = 1'b1;
            slotNext.id       = KEY_ID_W'(ptrNext);
            slotNext.isRepeat = |(pendRep & grantMask);
        end

        // A key whose event sits unaccepted in the slot still owns its one
        // outstanding event, so a new edge for it is dropped.
        for (int i = 0; i < NUM_KEYS; i++) begin
            slotBusy[i] = event_valid && !event_ready && (slot.id == KEY_ID_W'(i));
        end

        // A key being granted this cycle frees its pending bit, so an edge
        // arriving on that same cycle is kept (set wins over clear).
        dropMask    = setMask & ((pending & ~grantMask) | slotBusy);
        acceptMask  = setMask & ~dropMask;
        pendingNext = (pending & ~grantMask) | acceptMask;
        pendRepNext = (pendRep & ~acceptMask) | (acceptMask & repEdge & ~pressEdge);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= '0;
            pendRep     <= '0;
            slot        <= '0;
            event_valid <= 1'b0;
            ptr         <= '0;
            overflow    <= 1'b0;
        end else begin
            pending     <= pendingNext;
            pendRep     <= pendRepNext;
            slot        <= slotNext;
            event_valid <= slotValidNext;
            ptr         <= ptrNext;
            overflow    <= |dropMask;
        end
    end

    assign event_id     = slot.id[IDW-1:0];
    assign event_repeat = slot.isRepeat;

endmodule

// File: tb/tb_key_event_arbiter.sv
// ----------------------------------------------------------------------------
// tb_key_event_arbiter
//
// Directed bench for key_event_arbiter with NUM_KEYS=4, DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20, REPEAT_RATE=10. The repeat scenario is compiled only when
// KEY_AUTOREPEAT_EN is defined.
// ----------------------------------------------------------------------------
module tb_key_event_arbiter;

    localparam int NK     = 4;
    localparam int DEB    = 4;
    localparam int RDELAY = 20;
    localparam int RRATE  = 10;
    localparam int IDW    = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [NK-1:0]  keysN;
    logic [NK-1:0]  pressed;
    logic           event_valid;
    logic           event_ready;
    logic [IDW-1:0] event_id;
    logic           event_repeat;
    logic           overflow;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] exp_q[$];

    key_event_arbiter #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDELAY),
        .REPEAT_RATE    (RRATE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keysN       (keysN),
        .pressed     (pressed),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_id    (event_id),
        .event_repeat(event_repeat),
        .overflow    (overflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver / checker tasks ----------------
    // Advance n rising edges; land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Count cycles with event_valid and with overflow over n edges.
    task automatic watch(input int n, output int nValid, output int nOverflow);
        nValid    = 0;
        nOverflow = 0;
        for (int c = 0; c < n; c++) begin
            tick(1);
            if (event_valid) nValid++;
            if (overflow) nOverflow++;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          nv;
        int          nov;
        int          nb;
        int          ovCount;
        int          ovAt;
        logic        holdOk;
        logic [15:0] expv;

        reset       = 1'b1;
        keysN       = '1;
        event_ready = 1'b1;

        // Reset state
        tick(1);
        check("reset_pressed", pressed, 0);
        check("reset_valid", event_valid, 0);
        check("reset_id", event_id, 0);
        check("reset_repeat", event_repeat, 0);
        check("reset_overflow", overflow, 0);
        tick(1);
        reset = 1'b0;
        tick(3);

        // Keys 0,1,3 together, pointer at 0: order 1,3,0 back to back
        keysN = 4'b0100;
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd0);
        tick(6);
        check("rr_pressed", pressed, 4'b1011);
        check("rr_idle_before", event_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            expv = exp_q.pop_front();
            check("rr_valid", event_valid, 1);
            check("rr_id", event_id, expv);
        end
        tick(1);
        check("rr_drained", event_valid, 0);
        keysN = '1;
        watch(10, nv, nov);
        check("rr_release_no_event", nv, 0);

        // Single press of key 2
        keysN = 4'b1011;
        tick(4);
        check("single_pressed_early", pressed, 0);
        tick(1);
        check("single_pressed", pressed, 4'b0100);
        tick(1);
        check("single_not_yet", event_valid, 0);
        tick(1);
        check("single_valid", event_valid, 1);
        check("single_id", event_id, 2);
        check("single_repeat", event_repeat, 0);
        watch(10, nv, nov);
        check("single_once", nv, 0);
        keysN = '1;
        tick(4);
        check("release_still_held", pressed, 4'b0100);
        tick(1);
        check("release_pressed", pressed, 0);
        watch(10, nv, nov);
        check("release_no_event", nv, 0);

        // Bounce on key 1, then settle low
        nb = 0;
        for (int b = 0; b < 10; b++) begin
            keysN[1] = 1'b0;
            watch(2, nv, nov);
            nb += nv;
            keysN[1] = 1'b1;
            watch(2, nv, nov);
            nb += nv;
        end
        check("bounce_no_event", nb, 0);
        check("bounce_pressed", pressed, 0);
        keysN[1] = 1'b0;
        tick(6);
        check("bounce_settle_wait", event_valid, 0);
        tick(1);
        check("bounce_valid", event_valid, 1);
        check("bounce_id", event_id, 1);
        tick(1);
        check("bounce_once", event_valid, 0);
        keysN = '1;
        tick(8);

        // Stalled consumer: second press of key 0 is dropped
        event_ready = 1'b0;
        keysN[0]    = 1'b0;
        tick(7);
        check("stall_valid", event_valid, 1);
        check("stall_id", event_id, 0);
        holdOk   = 1'b1;
        ovCount  = 0;
        ovAt     = 0;
        keysN[0] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick(1);
            holdOk &= (event_valid === 1'b1) && (event_id === 2'd0);
            if (overflow) ovCount++;
        end
        keysN[0] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick(1);
            holdOk &= (event_valid === 1'b1) && (event_id === 2'd0);
            if (overflow) begin
                ovCount++;
                ovAt = c;
            end
        end
        keysN[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            holdOk &= (event_valid === 1'b1) && (event_id === 2'd0);
            if (overflow) ovCount++;
        end
        check("stall_hold_stable", holdOk, 1);
        check("stall_overflow_count", ovCount, 1);
        check("stall_overflow_cycle", ovAt, 6);
        event_ready = 1'b1;
        tick(1);
        check("stall_accepted", event_valid, 0);
        watch(10, nv, nov);
        check("stall_single_event", nv, 0);

        // Reset while an event is held and another is pending
        event_ready = 1'b0;
        keysN       = 4'b1001;
        tick(7);
        check("midreset_valid_before", event_valid, 1);
        check("midreset_id_before", event_id, 1);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_valid", event_valid, 0);
        check("midreset_id", event_id, 0);
        check("midreset_pressed", pressed, 0);
        check("midreset_overflow", overflow, 0);
        check("midreset_repeat", event_repeat, 0);
        keysN = '1;
        tick(2);
        reset = 1'b0;
        event_ready = 1'b1;
        watch(15, nv, nov);
        check("midreset_no_stale", nv, 0);
        check("midreset_no_overflow", nov, 0);

`ifdef KEY_AUTOREPEAT_EN
        // Hold key 3: press at +7, repeats at +27, +37, +47 (encoded cycle*2+repeat)
        exp_q.delete();
        exp_q.push_back(16'd14);
        exp_q.push_back(16'd55);
        exp_q.push_back(16'd75);
        exp_q.push_back(16'd95);
        nv       = 0;
        keysN[3] = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            tick(1);
            if (event_valid) begin
                nv++;
                check("rep_id", event_id, 3);
                if (exp_q.size() > 0) begin
                    expv = exp_q.pop_front();
                    check("rep_timing", c * 2 + int'(event_repeat), expv);
                end
            end
            if (c == 48) keysN[3] = 1'b1;
        end
        check("rep_event_count", nv, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
